// File: rtl/jtag_bitbang_ctrl.sv
// Remote-bitbang JTAG engine: decodes OpenOCD command bytes from a small FIFO,
// drives per-chain TAP pins and returns TDO samples on a response stream.
module jtag_bitbang_ctrl #(
    parameter int          NUM_CHAINS     = 1,
    parameter int          TICK_DIV       = 1,
    parameter int          CMD_FIFO_DEPTH = 4,
    parameter logic [31:0] EXIT_CODE      = 32'd1,
    localparam int         CW             = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [7:0]            cmd_data_i,
    input  logic [CW-1:0]         cmd_chain_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [7:0]            rsp_data_o,
    output logic [NUM_CHAINS-1:0] jtag_tck_o,
    output logic [NUM_CHAINS-1:0] jtag_tms_o,
    output logic [NUM_CHAINS-1:0] jtag_tdi_o,
    output logic [NUM_CHAINS-1:0] jtag_trst_n_o,
    input  logic [NUM_CHAINS-1:0] jtag_tdo_i,
    output logic                  srst_n_o,
    output logic [31:0]           exit_o,
    output logic [7:0]            err_cnt_o
);

    localparam int              AW        = $clog2(CMD_FIFO_DEPTH);
    localparam int              EW        = CW + 8;
    localparam int              HW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW:0]     NC        = (CW+1)'(NUM_CHAINS);
    localparam logic [HW-1:0]   HOLD_LOAD = HW'(TICK_DIV - 1);
    localparam logic [HW-1:0]   HOLD_ONE  = 1;
    localparam logic [AW:0]     PTR_ONE   = 1;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] HOLD     = 2'd1;
    localparam logic [1:0] WAIT_RSP = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;

    logic [1:0]            rst_sync;
    logic                  rst_n;
    logic [EW-1:0]         mem [CMD_FIFO_DEPTH];
    logic [AW:0]           wr_ptr, rd_ptr;
    logic                  full, empty, push, pop;
    logic [EW-1:0]         head;
    logic [7:0]            pop_byte;
    logic [CW-1:0]         pop_chain;
    logic [NUM_CHAINS-1:0] chain_sel;
    logic                  chain_ok, tdo_bit;
    logic                  is_pin, is_read, is_rst, is_blink, is_quit, cmd_bad;
    logic [1:0]            rst_code;
    logic [1:0]            state;
    logic [HW-1:0]         hold_cnt;
    logic [NUM_CHAINS-1:0] tck, tms, tdi, trst_n;
    logic                  srst_n, rsp_valid;
    logic [7:0]            rsp_data, err_cnt;
    logic [31:0]           exit_q;

    // Reset asserts immediately but releases only on a clock edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rst_sync <= 2'b00;
        else         rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign push  = cmd_valid_i && !full;
    assign pop   = !empty && (((state == IDLE) && enable_i) || (state == DONE));

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {cmd_chain_i, cmd_data_i};
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    assign head      = mem[rd_ptr[AW-1:0]];
    assign pop_byte  = head[7:0];
    assign pop_chain = head[EW-1:8];
    assign chain_ok  = ({1'b0, pop_chain} < NC);
    assign is_pin    = (pop_byte[7:3] == 5'b00110);
    assign is_read   = (pop_byte == 8'h52);
    assign is_rst    = (pop_byte >= 8'h72) && (pop_byte <= 8'h75);
    assign is_blink  = (pop_byte == 8'h42) || (pop_byte == 8'h62);
    assign is_quit   = (pop_byte == 8'h51);
    assign cmd_bad   = !(is_pin || is_read || is_rst || is_blink || is_quit);
    // 'r'..'u' map to {trst,srst} = 0..3
    assign rst_code  = pop_byte[1:0] - 2'd2;
    assign tdo_bit   = |(jtag_tdo_i & chain_sel);

    always_comb begin
        chain_sel = '0;
        for (int i = 0; i < NUM_CHAINS; i++) chain_sel[i] = (pop_chain == CW'(i));
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            tck       <= '0;
            tms       <= '1;
            tdi       <= '0;
            trst_n    <= '1;
            srst_n    <= 1'b1;
            exit_q    <= '0;
            err_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h30;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        if (!chain_ok || cmd_bad) begin
                            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                        end else if (is_pin) begin
                            tck      <= (tck & ~chain_sel) | ({NUM_CHAINS{pop_byte[2]}} & chain_sel);
                            tms      <= (tms & ~chain_sel) | ({NUM_CHAINS{pop_byte[1]}} & chain_sel);
                            tdi      <= (tdi & ~chain_sel) | ({NUM_CHAINS{pop_byte[0]}} & chain_sel);
                            hold_cnt <= HOLD_LOAD;
                            state    <= HOLD;
                        end else if (is_rst) begin
                            trst_n   <= (trst_n & ~chain_sel) | ({NUM_CHAINS{~rst_code[1]}} & chain_sel);
                            srst_n   <= ~rst_code[0];
                            hold_cnt <= HOLD_LOAD;
                            state    <= HOLD;
                        end else if (is_read) begin
                            rsp_data  <= {7'b0011000, tdo_bit};
                            rsp_valid <= 1'b1;
                            state     <= WAIT_RSP;
                        end else if (is_quit) begin
                            exit_q <= EXIT_CODE;
                            state  <= DONE;
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0) state <= IDLE;
                    else                hold_cnt <= hold_cnt - HOLD_ONE;
                end
                WAIT_RSP: begin
                    if (rsp_ready_i) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                DONE:    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    assign cmd_ready_o   = !full;
    assign rsp_valid_o   = rsp_valid;
    assign rsp_data_o    = rsp_data;
    assign jtag_tck_o    = tck;
    assign jtag_tms_o    = tms;
    assign jtag_tdi_o    = tdi;
    assign jtag_trst_n_o = trst_n;
    assign srst_n_o      = srst_n;
    assign exit_o        = exit_q;
    assign err_cnt_o     = err_cnt;

endmodule

// File: tb/tb_jtag_bitbang_ctrl.sv
// Bench for jtag_bitbang_ctrl: directed scenarios plus random command streams
// checked against a per-chain pin model of the remote_bitbang protocol.
module tb_jtag_bitbang_ctrl;

    localparam int TICK_DIV = 3;

    logic        clk = 1'b0;
    logic        rst_n, enable, cmd_valid, cmd_ready, rsp_valid, rsp_ready, srst_n;
    logic [7:0]  cmd_data, rsp_data, err_cnt;
    logic [1:0]  cmd_chain;
    logic [2:0]  tck, tms, tdi, trst_n, tdo;
    logic [31:0] exit_code;

    int total = 0;
    int bad   = 0;

    logic [2:0]  m_tck, m_tms, m_tdi, m_trst_n;
    logic        m_srst_n;
    int          m_err;
    logic [31:0] m_exit;
    bit          m_done;
    logic [7:0]  exp_rsp[$];

    jtag_bitbang_ctrl #(
        .NUM_CHAINS(3), .TICK_DIV(TICK_DIV), .CMD_FIFO_DEPTH(4), .EXIT_CODE(32'd1)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_data_i(cmd_data), .cmd_chain_i(cmd_chain),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .jtag_tck_o(tck), .jtag_tms_o(tms), .jtag_tdi_o(tdi),
        .jtag_trst_n_o(trst_n), .jtag_tdo_i(tdo),
        .srst_n_o(srst_n), .exit_o(exit_code), .err_cnt_o(err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_tck = 3'b000; m_tms = 3'b111; m_tdi = 3'b000; m_trst_n = 3'b111;
        m_srst_n = 1'b1; m_err = 0; m_exit = 32'd0; m_done = 1'b0;
        exp_rsp.delete();
    endtask

    // Protocol-level effect of one command byte on the bridge state.
    task automatic model_apply(input logic [7:0] b, input int ch);
        logic [7:0] v;
        if (m_done) return;
        if (ch >= 3) begin
            if (m_err < 255) m_err++;
            return;
        end
        if (b >= 8'h30 && b <= 8'h37) begin
            v = b - 8'h30;
            m_tck[ch] = v[2]; m_tms[ch] = v[1]; m_tdi[ch] = v[0];
        end else if (b == 8'h52) begin
            exp_rsp.push_back(8'h30 + {7'd0, tdo[ch]});
        end else if (b >= 8'h72 && b <= 8'h75) begin
            v = b - 8'h72;
            m_trst_n[ch] = ~v[1]; m_srst_n = ~v[0];
        end else if (b == 8'h42 || b == 8'h62) begin
            m_exit = m_exit;
        end else if (b == 8'h51) begin
            m_exit = 32'd1; m_done = 1'b1;
        end else if (m_err < 255) begin
            m_err++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [1:0] ch);
        int guard = 0;
        while (cmd_ready !== 1'b1 && guard < 200) begin
            tick(1);
            guard++;
        end
        if (cmd_ready !== 1'b1) begin
            total++; bad++;
            $display("[TB] FAIL send_ready got=%b want=1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_data = b; cmd_chain = ch;
        model_apply(b, int'(ch));
        tick(1);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        total++;
        if (exit_code !== 32'd0) begin bad++; $display("[TB] FAIL rst_exit_in got=%h want=0", exit_code); end
        rst_n = 1'b1;
        tick(4);
        total += 10;
        if (tck !== 3'b000)     begin bad++; $display("[TB] FAIL rst_tck got=%b want=000", tck); end
        if (tms !== 3'b111)     begin bad++; $display("[TB] FAIL rst_tms got=%b want=111", tms); end
        if (tdi !== 3'b000)     begin bad++; $display("[TB] FAIL rst_tdi got=%b want=000", tdi); end
        if (trst_n !== 3'b111)  begin bad++; $display("[TB] FAIL rst_trst got=%b want=111", trst_n); end
        if (srst_n !== 1'b1)    begin bad++; $display("[TB] FAIL rst_srst got=%b want=1", srst_n); end
        if (exit_code !== 0)    begin bad++; $display("[TB] FAIL rst_exit got=%h want=0", exit_code); end
        if (err_cnt !== 8'd0)   begin bad++; $display("[TB] FAIL rst_err got=%h want=0", err_cnt); end
        if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_rspv got=%b want=0", rsp_valid); end
        if (rsp_data !== 8'h30) begin bad++; $display("[TB] FAIL rst_rspd got=%h want=30", rsp_data); end
        if (cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_ready got=%b want=1", cmd_ready); end
    endtask

    task automatic test_pin_timing();
        int t[$];
        logic [1:0] seen[$];
        logic [1:0] prev, cur;
        enable = 1'b0;
        send_byte(8'h30, 2'd0);
        send_byte(8'h34, 2'd0);
        send_byte(8'h30, 2'd0);
        prev = {tck[0], tms[0]};
        enable = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            cur = {tck[0], tms[0]};
            if (cur !== prev) begin
                t.push_back(k);
                seen.push_back(cur);
            end
            prev = cur;
        end
        total++;
        if (t.size() != 3) begin bad++; $display("[TB] FAIL pin_changes got=%0d want=3", t.size()); end
        if (t.size() == 3) begin
            total += 5;
            if (t[0] != 1)           begin bad++; $display("[TB] FAIL first_pop got=%0d want=1", t[0]); end
            if (t[1] - t[0] != 4)    begin bad++; $display("[TB] FAIL spacing1 got=%0d want=4", t[1] - t[0]); end
            if (t[2] - t[1] != 4)    begin bad++; $display("[TB] FAIL spacing2 got=%0d want=4", t[2] - t[1]); end
            if (seen[1] !== 2'b10)   begin bad++; $display("[TB] FAIL tck_rise got=%b want=10", seen[1]); end
            if (seen[2] !== 2'b00)   begin bad++; $display("[TB] FAIL tck_fall got=%b want=00", seen[2]); end
        end
    endtask

    task automatic test_response();
        logic       tck1_before;
        int         guard = 0;
        tdo = 3'b010;
        tck1_before = m_tck[1];
        send_byte(8'h52, 2'd1);
        send_byte(8'h36, 2'd1);
        while (rsp_valid !== 1'b1 && guard < 10) begin tick(1); guard++; end
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'h31) begin
            bad++; $display("[TB] FAIL rsp_first got=%b/%h want=1/31", rsp_valid, rsp_data);
        end
        void'(exp_rsp.pop_front());
        for (int k = 0; k < 5; k++) begin
            tick(1);
            total++;
            if (rsp_valid !== 1'b1 || rsp_data !== 8'h31 || tck[1] !== tck1_before) begin
                bad++; $display("[TB] FAIL rsp_hold got=%b/%h/%b want=1/31/%b",
                                rsp_valid, rsp_data, tck[1], tck1_before);
            end
        end
        rsp_ready = 1'b1;
        tick(1);
        rsp_ready = 1'b0;
        total++;
        if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rsp_clear got=%b want=0", rsp_valid); end
        tick(TICK_DIV + 2);
        total++;
        if ({tck[1], tms[1], tdi[1]} !== 3'b110) begin
            bad++; $display("[TB] FAIL after_rsp_pin got=%b want=110", {tck[1], tms[1], tdi[1]});
        end
    endtask

    task automatic test_trst_srst();
        send_byte(8'h74, 2'd0);
        tick(6);
        total += 2;
        if (trst_n !== 3'b110) begin bad++; $display("[TB] FAIL t_trst got=%b want=110", trst_n); end
        if (srst_n !== 1'b1)   begin bad++; $display("[TB] FAIL t_srst got=%b want=1", srst_n); end
        send_byte(8'h73, 2'd0);
        tick(6);
        total += 2;
        if (trst_n !== 3'b111) begin bad++; $display("[TB] FAIL s_trst got=%b want=111", trst_n); end
        if (srst_n !== 1'b0)   begin bad++; $display("[TB] FAIL s_srst got=%b want=0", srst_n); end
    endtask

    task automatic test_fifo_full();
        logic [2:0] want[4] = '{3'b001, 3'b010, 3'b011, 3'b001};
        int idx = 0;
        enable = 1'b0;
        send_byte(8'h31, 2'd2);
        send_byte(8'h32, 2'd2);
        send_byte(8'h33, 2'd2);
        send_byte(8'h31, 2'd2);
        total += 2;
        if (cmd_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_ready got=%b want=0", cmd_ready); end
        if ({tck[2], tms[2], tdi[2]} !== 3'b010) begin
            bad++; $display("[TB] FAIL frozen_pins got=%b want=010", {tck[2], tms[2], tdi[2]});
        end
        enable = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick(1);
            if (k == 1) begin
                total++;
                if (cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL drain_ready got=%b want=1", cmd_ready); end
            end
            if ((k - 1) % (TICK_DIV + 1) == 0) begin
                total++;
                if ({tck[2], tms[2], tdi[2]} !== want[idx]) begin
                    bad++; $display("[TB] FAIL fifo_order%0d got=%b want=%b", idx, {tck[2], tms[2], tdi[2]}, want[idx]);
                end
                idx++;
            end
        end
        tick(4);
    endtask

    task automatic test_random();
        logic [7:0] b, want;
        logic [1:0] ch;
        int         r, guard;
        enable = 1'b1;
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 9);
            if (r < 4)       b = 8'h30 + 8'($urandom_range(0, 7));
            else if (r == 4) b = 8'h52;
            else if (r == 5) b = 8'h72 + 8'($urandom_range(0, 3));
            else if (r == 6) b = ($urandom_range(0, 1) == 0) ? 8'h42 : 8'h62;
            else begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'h51) b = 8'h52;
            end
            ch  = 2'($urandom_range(0, 3));
            tdo = 3'($urandom_range(0, 7));
            send_byte(b, ch);
            if (exp_rsp.size() > 0) begin
                want  = exp_rsp.pop_front();
                guard = 0;
                while (rsp_valid !== 1'b1 && guard < 10) begin tick(1); guard++; end
                total++;
                if (rsp_valid !== 1'b1 || rsp_data !== want) begin
                    bad++; $display("[TB] FAIL rnd_rsp n=%0d got=%b/%h want=1/%h", n, rsp_valid, rsp_data, want);
                end
                rsp_ready = 1'b1;
                tick(1);
                rsp_ready = 1'b0;
                tick(1);
            end else begin
                tick(TICK_DIV + 2);
            end
            total += 4;
            if ({tck, tms, tdi} !== {m_tck, m_tms, m_tdi}) begin
                bad++; $display("[TB] FAIL rnd_pins n=%0d b=%h ch=%0d got=%b want=%b", n, b, ch,
                                {tck, tms, tdi}, {m_tck, m_tms, m_tdi});
            end
            if ({trst_n, srst_n} !== {m_trst_n, m_srst_n}) begin
                bad++; $display("[TB] FAIL rnd_rst n=%0d got=%b want=%b", n, {trst_n, srst_n}, {m_trst_n, m_srst_n});
            end
            if (err_cnt !== m_err[7:0]) begin
                bad++; $display("[TB] FAIL rnd_err n=%0d got=%0d want=%0d", n, err_cnt, m_err);
            end
            if (rsp_valid !== 1'b0 || exit_code !== m_exit) begin
                bad++; $display("[TB] FAIL rnd_idle n=%0d got=%b/%h want=0/%h", n, rsp_valid, exit_code, m_exit);
            end
        end
    endtask

    task automatic test_errors();
        send_byte(8'h41, 2'd0);
        send_byte(8'h35, 2'd3);
        tick(4);
        total += 2;
        if (err_cnt !== m_err[7:0]) begin bad++; $display("[TB] FAIL err_two got=%0d want=%0d", err_cnt, m_err); end
        if ({tck, tms, tdi} !== {m_tck, m_tms, m_tdi}) begin
            bad++; $display("[TB] FAIL err_pins got=%b want=%b", {tck, tms, tdi}, {m_tck, m_tms, m_tdi});
        end
        for (int k = 0; k < 300; k++) send_byte(8'h41, 2'd0);
        tick(4);
        total++;
        if (err_cnt !== 8'd255) begin bad++; $display("[TB] FAIL err_sat got=%0d want=255", err_cnt); end
    endtask

    task automatic test_quit();
        send_byte(8'h51, 2'd0);
        send_byte(8'h37, 2'd0);
        tick(6);
        total += 4;
        if (exit_code !== 32'd1) begin bad++; $display("[TB] FAIL quit_exit got=%h want=1", exit_code); end
        if ({tck, tms, tdi} !== {m_tck, m_tms, m_tdi}) begin
            bad++; $display("[TB] FAIL quit_pins got=%b want=%b", {tck, tms, tdi}, {m_tck, m_tms, m_tdi});
        end
        if (err_cnt !== m_err[7:0]) begin bad++; $display("[TB] FAIL quit_err got=%0d want=%0d", err_cnt, m_err); end
        if (cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL quit_drain got=%b want=1", cmd_ready); end
    endtask

    task automatic test_async_reset();
        int guard = 0;
        #3 rst_n = 1'b0;
        #1;
        total += 3;
        if (exit_code !== 32'd0) begin bad++; $display("[TB] FAIL ar_exit got=%h want=0", exit_code); end
        if ({tck, tms, tdi, trst_n, srst_n} !== 13'b000_111_000_111_1) begin
            bad++; $display("[TB] FAIL ar_pins got=%b", {tck, tms, tdi, trst_n, srst_n});
        end
        if (err_cnt !== 8'd0) begin bad++; $display("[TB] FAIL ar_err got=%0d want=0", err_cnt); end
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        tick(4);

        send_byte(8'h37, 2'd1);
        tick(2);
        total++;
        if (tck[1] !== 1'b1) begin bad++; $display("[TB] FAIL hold_pin got=%b want=1", tck[1]); end
        #3 rst_n = 1'b0;
        #1;
        total++;
        if ({tck, tms, tdi} !== 9'b000_111_000) begin
            bad++; $display("[TB] FAIL hold_rst got=%b want=000111000", {tck, tms, tdi});
        end
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        tick(4);

        tdo = 3'b001;
        send_byte(8'h52, 2'd0);
        while (rsp_valid !== 1'b1 && guard < 10) begin tick(1); guard++; end
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'h31) begin
            bad++; $display("[TB] FAIL wait_rsp got=%b/%h want=1/31", rsp_valid, rsp_data);
        end
        #3 rst_n = 1'b0;
        #1;
        total++;
        if (rsp_valid !== 1'b0 || rsp_data !== 8'h30) begin
            bad++; $display("[TB] FAIL wait_rst got=%b/%h want=0/30", rsp_valid, rsp_data);
        end
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        tick(4);

        send_byte(8'h33, 2'd0);
        tick(6);
        total++;
        if ({tck, tms, tdi} !== {m_tck, m_tms, m_tdi}) begin
            bad++; $display("[TB] FAIL post_rst_pins got=%b want=%b", {tck, tms, tdi}, {m_tck, m_tms, m_tdi});
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; cmd_valid = 1'b0; cmd_data = 8'h00;
        cmd_chain = 2'd0; rsp_ready = 1'b0; tdo = 3'b000;
        model_reset();
        test_reset();
        test_pin_timing();
        test_response();
        test_trst_srst();
        test_fifo_full();
        test_random();
        test_errors();
        test_quit();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jtag_bitbang_ctrl.md
Name: jtag_bitbang_ctrl

Overview:
Synthesisable, parametrised JTAG bit-bang engine for simulation tops and hardware debug bridges. It consumes OpenOCD remote_bitbang command bytes from a valid/ready stream and drives TCK/TMS/TDI/TRSTn on one of NUM_CHAINS TAP chains, with programmable tick spacing. TDO reads return on a response stream, and a quit command raises a sticky exit code that the top level uses to end simulation. It generalises the fixed single-chain, fixed-tick JTAG bridge: multi-chain select, a command FIFO, a configurable half-period, a system-reset output and error accounting.

Parameters:
NUM_CHAINS, 1, number of independent TAP chains (1..8).
TICK_DIV, 1, clk_i cycles pins are held after each pin update (>=1).
CMD_FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2).
EXIT_CODE, 32'd1, value loaded into exit_o on 'Q'.
CW, max(1,$clog2(NUM_CHAINS)), chain-select width (derived, localparam).

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
enable_i  in  1  engine may pop commands when high
cmd_valid_i  in  1  command byte valid
cmd_ready_o  out  1  FIFO not full
cmd_data_i  in  8  remote_bitbang ASCII byte
cmd_chain_i  in  CW  target chain for this byte
rsp_valid_o  out  1  TDO response valid
rsp_ready_i  in  1  response accepted
rsp_data_o  out  8  0x30 or 0x31
jtag_tck_o  out  NUM_CHAINS  per-chain TCK
jtag_tms_o  out  NUM_CHAINS  per-chain TMS
jtag_tdi_o  out  NUM_CHAINS  per-chain TDI
jtag_trst_n_o  out  NUM_CHAINS  per-chain TRSTn
jtag_tdo_i  in  NUM_CHAINS  per-chain TDO
srst_n_o  out  1  system reset request, active low
exit_o  out  32  0 while running, EXIT_CODE after 'Q'
err_cnt_o  out  8  dropped-command count, saturating

Behaviour:
- Reset is async assert, sync deassert. Reset values: tck=0, tms=1, tdi=0, trst_n=1 on all chains; srst_n_o=1; exit_o=0; err_cnt_o=0; rsp_valid_o=0; rsp_data_o=0x30; FIFO empty; cmd_ready_o=1.
- FIFO: {chain, byte} is pushed on cmd_valid_i & cmd_ready_o. cmd_ready_o = !full, with no pop bypass: when full, ready stays 0 even in a pop cycle.
- FSM states: IDLE, HOLD, WAIT_RSP, DONE.
- IDLE: if enable_i and FIFO is non-empty, pop and decode in the same cycle. Register updates land on that edge. enable_i low leaves pins frozen; the FIFO still fills.
- '0'..'7' (0x30..0x37): selected chain gets tck=b[2], tms=b[1], tdi=b[0]. Go to HOLD for TICK_DIV cycles, then IDLE. Minimum pop spacing is TICK_DIV+1 cycles. Unselected chains hold their values.
- 'R': sample jtag_tdo_i[chain] at the pop edge. rsp_data_o=0x30|tdo, rsp_valid_o=1, go to WAIT_RSP. Leave on rsp_ready_i, which clears rsp_valid_o, then return to IDLE. rsp_data_o is stable while valid.
- 'r','s','t','u': set {trst,srst} = {0,0},{0,1},{1,0},{1,1} respectively (1 = asserted). jtag_trst_n_o[chain]=~trst, srst_n_o=~srst. Go to HOLD as for pin writes.
- 'B','b' (blink): consumed, no effect, return to IDLE next cycle.
- 'Q': exit_o=EXIT_CODE and go to DONE. DONE pops and discards every byte (no pin change, no err count) until reset; pins hold.
- Any other byte, or chain >= NUM_CHAINS: dropped, err_cnt_o+1 saturating at 255, stay IDLE.
- Reset mid-HOLD or mid-WAIT_RSP: FIFO contents and pending response are lost, outputs return to reset values.
- Push to a full FIFO is not possible (ready low). A push while the engine pops a non-full FIFO proceeds normally (occupancy unchanged).

Test Plan:
- Reset, then bytes "0","4","0" on chain 0 with TICK_DIV=3 -> tck 0,1,0; consecutive pin updates exactly 4 cycles apart; tms=0.
- TICK_DIV=1, NUM_CHAINS=2: "R" on chain 1 with tdo_i=2'b10 -> rsp_data_o=0x31. Hold rsp_ready_i low 5 cycles -> rsp_valid_o stays 1, data stable, next command not popped.
- "t" on chain 0 -> jtag_trst_n_o[0]=0, srst_n_o=1, chain 1 unchanged. Then "s" -> trst_n[0]=1, srst_n_o=0.
- enable_i=0, push 4 bytes with CMD_FIFO_DEPTH=4 -> cmd_ready_o=0 after the 4th push. Raise enable_i -> all 4 bytes execute in order.
- Bytes 0x41 'A', then "5" on chain 3 with NUM_CHAINS=3 -> err_cnt_o=2, pins unchanged. 300 bad bytes -> err_cnt_o saturates at 255.
- "Q" then "7" -> exit_o=1, "7" consumed with no pin change. Async rst_ni pulse -> exit_o=0, pins at reset values.
